// File: rtl/enhanced_multijoy.sv
// N-player joystick conditioner: two-flop sync, optional debounce (MULTIJOY_DEBOUNCE_EN),
// SOCD cleaning and per-player 8/4/2-way resolution with a change pulse.
module enhanced_multijoy #(
    parameter int N_PLAYERS       = 2,
    parameter int SOCD_UD         = 0,
    parameter int SOCD_LR         = 0,
    parameter int FOUR_WAY_POLICY = 0,
    parameter int TIE_AXIS        = 0,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [4*N_PLAYERS-1:0] dirinput,
    input  logic [2*N_PLAYERS-1:0] mode,
    output logic [4*N_PLAYERS-1:0] diroutput,
    output logic [N_PLAYERS-1:0]   changed
);

    // Pair is {up,down} or {left,right}; newest_hi=1 means the first bit rose last.
    function automatic logic [1:0] socd_pair(input logic [1:0] bits, input int policy,
                                             input logic newest_hi);
        logic [1:0] res;
        res = bits;
        if (bits == 2'b11) begin
            case (policy)
                1:       res = 2'b10;
                2:       res = 2'b01;
                3:       res = newest_hi ? 2'b10 : 2'b01;
                default: res = 2'b00;
            endcase
        end
        return res;
    endfunction

    function automatic logic [3:0] four_way(input logic [3:0] c, input logic vert_last,
                                            input logic [3:0] prev);
        logic [3:0] newest;
        logic [3:0] res;
        newest = vert_last ? {c[3:2], 2'b00} : {2'b00, c[1:0]};
        res    = c;
        if ((|c[3:2]) && (|c[1:0])) begin
            case (FOUR_WAY_POLICY)
                1:       res = ((|prev) && !((|prev[3:2]) && (|prev[1:0]))) ? prev : newest;
                2:       res = {2'b00, c[1:0]};
                3:       res = {c[3:2], 2'b00};
                default: res = newest;
            endcase
        end
        return res;
    endfunction

    for (genvar p = 0; p < N_PLAYERS; p++) begin : g_player
        logic [3:0] sync_p0, sync_p1;
        logic [3:0] raw, raw_prev, rise_raw;
        logic [3:0] clean, clean_prev, resolved;
        logic [3:0] out_p2, out_prev;
        logic       changed_p2;
        logic       newest_ud, newest_lr, newest_ud_nx, newest_lr_nx;
        logic       axis_last, axis_last_nx, rise_v, rise_h;
        logic [1:0] act_mode, act_mode_nx;

`ifdef MULTIJOY_DEBOUNCE_EN
        localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
        logic [CW-1:0] cnt [4];
        logic [3:0]    accepted;

        // Debounce boundary: a bit is accepted after DEBOUNCE_CYCLES differing cycles.
        always_ff @(posedge clock) begin
            if (reset) begin
                accepted <= '0;
                for (int b = 0; b < 4; b++) cnt[b] <= '0;
            end else begin
                for (int b = 0; b < 4; b++) begin
                    if (sync_p1[b] == accepted[b]) begin
                        cnt[b] <= '0;
                    end else if (cnt[b] == CW'(DEBOUNCE_CYCLES - 1)) begin
                        accepted[b] <= sync_p1[b];
                        cnt[b]      <= '0;
                    end else begin
                        cnt[b] <= cnt[b] + CW'(1);
                    end
                end
            end
        end
        assign raw = accepted;
`else
        assign raw = sync_p1;
`endif

        always_comb begin
            rise_raw     = raw & ~raw_prev;
            newest_ud_nx = rise_raw[3] ? 1'b1 : (rise_raw[2] ? 1'b0 : newest_ud);
            newest_lr_nx = rise_raw[1] ? 1'b1 : (rise_raw[0] ? 1'b0 : newest_lr);
            clean        = {socd_pair(raw[3:2], SOCD_UD, newest_ud_nx),
                            socd_pair(raw[1:0], SOCD_LR, newest_lr_nx)};
            rise_v       = |(clean[3:2] & ~clean_prev[3:2]);
            rise_h       = |(clean[1:0] & ~clean_prev[1:0]);
            if (rise_v && rise_h)  axis_last_nx = (TIE_AXIS != 0);
            else if (rise_v)       axis_last_nx = 1'b1;
            else if (rise_h)       axis_last_nx = 1'b0;
            else                   axis_last_nx = axis_last;
            // A new mode only takes effect while the player is neutral.
            act_mode_nx  = (clean == 4'b0000) ? mode[2*p +: 2] : act_mode;
            case (act_mode_nx)
                2'b00:   resolved = clean;
                2'b01:   resolved = four_way(clean, axis_last_nx, out_p2);
                2'b10:   resolved = {2'b00, clean[1:0]};
                default: resolved = {clean[3:2], 2'b00};
            endcase
        end

        // Stages p0/p1 synchronise; stage p2 registers the resolved output.
        always_ff @(posedge clock) begin
            if (reset) begin
                sync_p0    <= '0;
                sync_p1    <= '0;
                raw_prev   <= '0;
                clean_prev <= '0;
                newest_ud  <= 1'b1;
                newest_lr  <= 1'b1;
                axis_last  <= (TIE_AXIS != 0);
                act_mode   <= 2'b00;
                out_p2     <= '0;
                out_prev   <= '0;
                changed_p2 <= 1'b0;
            end else begin
                sync_p0    <= dirinput[4*p +: 4];
                sync_p1    <= sync_p0;
                raw_prev   <= raw;
                clean_prev <= clean;
                newest_ud  <= newest_ud_nx;
                newest_lr  <= newest_lr_nx;
                axis_last  <= axis_last_nx;
                act_mode   <= act_mode_nx;
                out_p2     <= resolved;
                out_prev   <= out_p2;
                changed_p2 <= (out_p2 != out_prev);
            end
        end

        assign diroutput[4*p +: 4] = out_p2;
        assign changed[p]          = changed_p2;
    end

endmodule
